// File: rtl/sysex_pkg.sv
// Shared constants, FSM state type and byte helpers for the SysEx patch dump.
// Ports: none (package).
package sysex_pkg;

  localparam logic [7:0] SYX_SOF = 8'hF0;
  localparam logic [7:0] SYX_EOF = 8'hF7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_SETUP,
    S_STROBE,
    S_SETTLE,
    S_CAPTURE,
    S_SEND_HI,
    S_SEND_LO,
    S_NEXT,
    S_CHK,
    S_EOX
  } state_t;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } nib_t;

  // Split a raw parameter byte into two 7-bit-safe payload bytes.
  function automatic nib_t nib_split(input logic [7:0] b);
    nib_t n;
    n.hi = {4'h0, b[7:4]};
    n.lo = {4'h0, b[3:0]};
    return n;
  endfunction

  // (0x80 - sum7) & 0x7F is the 7-bit two's complement of sum7.
  function automatic logic [7:0] chk_byte(input logic [6:0] sum7);
    logic [6:0] n;
    n = 7'd0 - sum7;
    return {1'b0, n};
  endfunction

endpackage

// File: rtl/sysex_tx_byte_reg.sv
// Registered tx byte slot with valid/ready handshake.
// Ports: load/load_data in, tx_data/tx_valid out, tx_ready in, accepted out.
module sysex_tx_byte_reg (
  input  logic       iRST_N,
  input  logic       sCLK_XVXOSC,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       accepted
);

  assign accepted = tx_valid & tx_ready;

  always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
    if (!iRST_N) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (load && !tx_valid) begin
      tx_data  <= load_data;
      tx_valid <= 1'b1;
    end else if (accepted) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sysex_patch_dump.sv
// Walks all parameter banks over the shared bus and streams a SysEx dump.
// Ports: start/patch_no in, busy/done out, adr/bank_sel/read/save bus, tx stream.
module sysex_patch_dump
  import sysex_pkg::*;
#(
  parameter int         NBANKS     = 4,
  parameter logic [6:0] ADR_LAST   = 7'd127,
  parameter int         STROBE_CYC = 2,
  parameter int         SETTLE_CYC = 2,
  parameter logic [7:0] MFR_ID     = 8'h7D,
  parameter logic [7:0] DEV_ID     = 8'h00
) (
  input  logic              iRST_N,
  input  logic              sCLK_XVXOSC,
  input  logic              start,
  input  logic [6:0]        patch_no,
  output logic              busy,
  output logic              done,
  output logic [6:0]        adr,
  output logic [NBANKS-1:0] bank_sel,
  output logic              read,
  output logic              sysex_data_patch_save,
  input  logic [7:0]        data_in,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  state_t          state;
  logic [1:0]      hidx;
  logic [7:0]      cnt;
  logic [BW-1:0]   bank;
  logic [7:0]      pbyte;
  logic [6:0]      patch_q;
  logic [6:0]      sum7;
  logic            pend;

  logic            load;
  logic            acc;
  logic [7:0]      load_data;
  logic            is_send;
  logic            last_adr;
  logic [BW-1:0]   tgt;
  logic [NBANKS-1:0] sel_nxt;
  nib_t            nib;

  assign nib      = nib_split(pbyte);
  assign last_adr = (adr == ADR_LAST);

  // Bank selected on entry to SETUP; NEXT may be rolling to the next bank.
  assign tgt = (state == S_NEXT && last_adr) ? bank + 1'b1 : bank;

  always_comb begin
    sel_nxt = '0;
    for (int i = 0; i < NBANKS; i++)
      sel_nxt[i] = (tgt == BW'(i));
  end

  always_comb begin
    is_send = 1'b0;
    unique case (state)
      S_HDR, S_SEND_HI, S_SEND_LO, S_CHK, S_EOX: is_send = 1'b1;
      default: is_send = 1'b0;
    endcase
  end

  // One load per send state; pend blocks a reload until acceptance.
  assign load = is_send & ~pend;

  always_comb begin
    load_data = 8'h00;
    unique case (state)
      S_HDR: begin
        unique case (hidx)
          2'd0: load_data = SYX_SOF;
          2'd1: load_data = MFR_ID;
          2'd2: load_data = DEV_ID;
          2'd3: load_data = {1'b0, patch_q};
        endcase
      end
      S_SEND_HI: load_data = nib.hi;
      S_SEND_LO: load_data = nib.lo;
      S_CHK:     load_data = chk_byte(sum7);
      S_EOX:     load_data = SYX_EOF;
      default:   load_data = 8'h00;
    endcase
  end

  sysex_tx_byte_reg u_txr (
    .iRST_N      (iRST_N),
    .sCLK_XVXOSC (sCLK_XVXOSC),
    .load        (load),
    .load_data   (load_data),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .accepted    (acc)
  );

  always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
    if (!iRST_N) begin
      state                 <= S_IDLE;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      adr                   <= '0;
      bank_sel              <= '0;
      read                  <= 1'b0;
      sysex_data_patch_save <= 1'b0;
      hidx                  <= '0;
      cnt                   <= '0;
      bank                  <= '0;
      pbyte                 <= '0;
      patch_q               <= '0;
      sum7                  <= '0;
      pend                  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) pend <= 1'b1;
      if (acc) pend <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          patch_q <= patch_no;
          sum7    <= '0;
          busy    <= 1'b1;
          adr     <= '0;
          bank    <= '0;
          hidx    <= '0;
          state   <= S_HDR;
        end
        S_HDR: if (acc) begin
          hidx <= hidx + 2'd1;
          if (hidx == 2'd3) begin
            bank_sel              <= sel_nxt;
            sysex_data_patch_save <= 1'b1;
            state                 <= S_SETUP;
          end
        end
        S_SETUP: begin
          cnt   <= '0;
          read  <= 1'b1;
          state <= S_STROBE;
        end
        S_STROBE: begin
          if (cnt == 8'(STROBE_CYC - 1)) begin
            cnt   <= '0;
            read  <= 1'b0;
            state <= S_SETTLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_SETTLE: begin
          if (cnt == 8'(SETTLE_CYC - 1)) begin
            cnt   <= '0;
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_CAPTURE: begin
          pbyte                 <= data_in;
          sysex_data_patch_save <= 1'b0;
          bank_sel              <= '0;
          state                 <= S_SEND_HI;
        end
        S_SEND_HI: if (acc) begin
          sum7  <= sum7 + nib.hi[6:0];
          state <= S_SEND_LO;
        end
        S_SEND_LO: if (acc) begin
          sum7  <= sum7 + nib.lo[6:0];
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (last_adr) begin
            adr  <= '0;
            bank <= bank + 1'b1;
          end else begin
            adr <= adr + 7'd1;
          end
          if (last_adr && bank == BW'(NBANKS - 1)) begin
            state <= S_CHK;
          end else begin
            bank_sel              <= sel_nxt;
            sysex_data_patch_save <= 1'b1;
            state                 <= S_SETUP;
          end
        end
        S_CHK: if (acc) state <= S_EOX;
        S_EOX: if (acc) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysex_patch_dump.sv
// Directed bench for sysex_patch_dump: scoreboarded byte stream and bus model.
// Ports: none (top-level bench).
module tb_sysex_patch_dump;

  localparam int FRAME = 4 + 2 * 4 * 128 + 2;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, start_s;
  logic [6:0] patch, patch_s;
  logic       tx_ready, tx_ready_s;

  logic       busy, done, read, save, tx_valid;
  logic [6:0] adr;
  logic [3:0] bank_sel;
  logic [7:0] data_in, tx_data;

  logic       busy_s, done_s, read_s, save_s, tx_valid_s;
  logic [6:0] adr_s;
  logic [0:0] bank_sel_s;
  logic [7:0] data_in_s, tx_data_s;

  logic [7:0] image [512];
  logic [7:0] rf_q;
  logic       read_q;
  int         q [$];
  int         q_s [$];
  int         n_tests, n_fail;
  int         rx_idx, nrx_s, d_cnt, ds_cnt, nreads;
  int         ea, eb;

  assign data_in   = save ? rf_q : 8'h00;
  assign data_in_s = save_s ? ((adr_s == 7'd0) ? 8'hA5 : 8'h3C) : 8'h00;

  sysex_patch_dump u_dut (
    .iRST_N(rst_n), .sCLK_XVXOSC(clk), .start(start), .patch_no(patch),
    .busy(busy), .done(done), .adr(adr), .bank_sel(bank_sel),
    .read(read), .sysex_data_patch_save(save), .data_in(data_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  sysex_patch_dump #(.NBANKS(1), .ADR_LAST(7'd1)) u_sml (
    .iRST_N(rst_n), .sCLK_XVXOSC(clk), .start(start_s), .patch_no(patch_s),
    .busy(busy_s), .done(done_s), .adr(adr_s), .bank_sel(bank_sel_s),
    .read(read_s), .sysex_data_patch_save(save_s), .data_in(data_in_s),
    .tx_data(tx_data_s), .tx_valid(tx_valid_s), .tx_ready(tx_ready_s)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [6:0] p);
    int s;
    s = 0;
    q.push_back(32'hF0);
    q.push_back(32'h7D);
    q.push_back(32'h00);
    q.push_back(int'(p));
    for (int i = 0; i < 512; i++) begin
      q.push_back(int'(image[i] >> 4));
      q.push_back(int'(image[i] & 8'h0F));
      s += int'(image[i] >> 4) + int'(image[i] & 8'h0F);
    end
    q.push_back((128 - (s % 128)) % 128);
    q.push_back(32'hF7);
  endtask

  // One clock: sample at negedge, return #1 after the next posedge.
  task automatic step();
    int exp, bi;
    @(negedge clk);
    if (tx_valid && tx_ready) begin
      exp = (q.size() > 0) ? q.pop_front() : 32'h1FF;
      check("tx_byte", 32'(tx_data), exp);
      if (rx_idx >= 4 && rx_idx < FRAME - 1)
        check("payload_b7", 32'(tx_data[7]), 0);
      rx_idx++;
    end
    if (done) d_cnt++;
    if (!busy) begin
      ea = 0;
      eb = 0;
    end
    if (read && !read_q) begin
      check("adr_seq", 32'(adr), ea);
      check("bank_sel", 32'(bank_sel), 32'(1) << eb);
      check("onehot", 32'($onehot(bank_sel)), 1);
      bi = 0;
      for (int b = 0; b < 4; b++) if (bank_sel[b]) bi = b;
      rf_q = image[bi * 128 + int'(adr)];
      nreads++;
      if (ea == 127) begin
        ea = 0;
        eb++;
      end else begin
        ea++;
      end
    end
    read_q = read;
    if (tx_valid_s && tx_ready_s) begin
      exp = (q_s.size() > 0) ? q_s.pop_front() : 32'h1FF;
      check("sml_byte", 32'(tx_data_s), exp);
      nrx_s++;
    end
    if (done_s) ds_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev, c, s;
    n_tests = 0; n_fail = 0; rx_idx = 0; nrx_s = 0;
    d_cnt = 0; ds_cnt = 0; nreads = 0; ea = 0; eb = 0;
    rf_q = 8'h00; read_q = 1'b0;
    rst_n = 1'b0; start = 1'b0; start_s = 1'b0;
    patch = '0; patch_s = '0; tx_ready = 1'b0; tx_ready_s = 1'b1;
    for (int i = 0; i < 512; i++) image[i] = 8'($urandom);
    image[5] = 8'h80;

    repeat (3) step();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_adr", 32'(adr), 0);
    check("rst_bank_sel", 32'(bank_sel), 0);
    check("rst_read", 32'(read), 0);
    check("rst_save", 32'(save), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    rst_n = 1'b1;
    step();

    // Small instance: two parameters, checksum derived here.
    patch_s = 7'h15;
    q_s.push_back(32'hF0); q_s.push_back(32'h7D);
    q_s.push_back(32'h00); q_s.push_back(32'h15);
    q_s.push_back(32'h0A); q_s.push_back(32'h05);
    q_s.push_back(32'h03); q_s.push_back(32'h0C);
    s = 32'h0A + 32'h05 + 32'h03 + 32'h0C;
    q_s.push_back((128 - (s % 128)) % 128);
    q_s.push_back(32'hF7);
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    c = 0;
    while (ds_cnt == 0 && c < 500) begin step(); c++; end
    repeat (10) step();
    check("sml_done_once", 32'(ds_cnt), 1);
    check("sml_len", 32'(nrx_s), 10);
    check("sml_q_empty", 32'(q_s.size()), 0);
    check("sml_busy_end", 32'(busy_s), 0);

    // Full dump with a 50-cycle stall on the third byte and a stray start.
    patch = 7'h2A;
    push_frame(patch);
    rx_idx = 0; nreads = 0; prev = d_cnt;
    tx_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    c = 0;
    while (rx_idx < 2 && c < 50) begin step(); c++; end
    tx_ready = 1'b0;
    step();
    for (int k = 0; k < 50; k++) begin
      check("hold_valid", 32'(tx_valid), 1);
      check("hold_data", 32'(tx_data), 32'h00);
      check("hold_read", 32'(read), 0);
      check("hold_save", 32'(save), 0);
      start = (k == 10);
      step();
    end
    start = 1'b0;
    tx_ready = 1'b1;
    c = 0;
    while (d_cnt == prev && c < 20000) begin step(); c++; end
    repeat (20) step();
    check("full_done_once", 32'(d_cnt - prev), 1);
    check("full_len", 32'(rx_idx), FRAME);
    check("full_q_empty", 32'(q.size()), 0);
    check("full_reads", 32'(nreads), 512);
    check("full_busy_end", 32'(busy), 0);
    check("idle_bank_sel", 32'(bank_sel), 0);

    // Reset during a read strobe, then a clean dump.
    q.delete();
    push_frame(7'h11);
    patch = 7'h11;
    rx_idx = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (!read && c < 40) begin step(); c++; end
    check("reached_strobe", 32'(read), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_read", 32'(read), 0);
    check("mid_rst_save", 32'(save), 0);
    check("mid_rst_bank_sel", 32'(bank_sel), 0);
    check("mid_rst_tx_valid", 32'(tx_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    q.delete();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    push_frame(7'h33);
    patch = 7'h33;
    rx_idx = 0; nreads = 0; prev = d_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (d_cnt == prev && c < 20000) begin step(); c++; end
    repeat (5) step();
    check("post_rst_done", 32'(d_cnt - prev), 1);
    check("post_rst_len", 32'(rx_idx), FRAME);
    check("post_rst_q_empty", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
